pic_host_sequencer: RTL and testbench
=====================================

# pic_host_sequencer

CPU-side bus master for the 8259-style PIC control logic. After reset it programs the PIC: ICW1, ICW2, optional ICW3, optional ICW4, then OCW1. It then serves interrupts: it watches the PIC's INT output, drives the two-pulse INTA acknowledge, captures the vector byte, and issues a non-specific EOI when auto-EOI is off. It also forwards ad-hoc OCW writes from system logic.

## Interface
Parameters:
- WR_LOW_CYC, 2, cycles pic_wr_n is held low per write (≥1)
- INTA_LOW_CYC, 2, cycles of each INTA low pulse (≥1)
- INTA_GAP_CYC, 2, high cycles between INTA pulses (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_start  in  1  pulse; starts the init sequence; accepted only in IDLE
- cfg_sngl  in  1  ICW1 SNGL; 0 means also write ICW3
- cfg_ic4  in  1  ICW1 IC4; 1 means also write ICW4
- cfg_aeoi  in  1  ICW4 AEOI; 0 means an EOI is issued after each acknowledge
- cfg_vec_base  in  5  ICW2[7:3]
- cfg_icw3  in  8  ICW3 byte
- cfg_mask  in  8  initial OCW1 mask
- ocw_req  in  1  request an ad-hoc OCW write
- ocw_sel  in  2  01 selects OCW1, 10 selects OCW2, 11 selects OCW3; 00 is dropped and acked
- ocw_data  in  8  OCW byte; the D4/D3 bits for OCW2/OCW3 are forced by the block
- ocw_ack  out  1  one-cycle pulse in the cycle the OCW request is accepted
- pic_a0  out  1  PIC A0
- pic_dout  out  8  PIC write data
- pic_wr_n  out  1  PIC write strobe, active low
- pic_int  in  1  PIC INT; asynchronous
- pic_inta_n  out  1  PIC INTA, active low
- pic_din  in  8  PIC vector data
- vec_valid  out  1  one-cycle pulse; vec_data is valid
- vec_data  out  8  captured vector
- init_done  out  1  level; high once the init sequence completes
- busy  out  1  high whenever the block is not in IDLE

## Operation
- Reset values of all outputs:
  - pic_wr_n=1, pic_inta_n=1, pic_a0=0, pic_dout=0
  - vec_valid=0, vec_data=0, ocw_ack=0, init_done=0, busy=0
- Every write uses three phases:
  - W_SETUP: 1 cycle; a0 and dout driven, wr_n high.
  - W_STRB: WR_LOW_CYC cycles with wr_n low.
  - W_HOLD: 1 cycle; wr_n high, a0 and dout still held.
- Init byte list, each entry as (A0, data):
  - ICW1: (0, {3'b000,1,0,0,sngl,ic4})
  - ICW2: (1, {vec_base,3'b000})
  - ICW3: (1, icw3), only if sngl=0
  - ICW4: (1, {6'b0,aeoi,1}), only if ic4=1
  - OCW1: (1, mask)
  - cfg_* inputs are sampled into registers at init_start.
  - Writes run back-to-back; init_done is set in the cycle after the last W_HOLD.
  - A second init_start clears init_done and reruns the sequence.
- Ad-hoc OCW encoding:
  - OCW1 goes out as (1, data).
  - OCW2 goes out as (0, {data[7:5],2'b00,data[2:0]}).
  - OCW3 goes out as (0, {data[7:5],2'b01,data[2:0]}).
- pic_int passes through a 2-flop synchronizer, giving int_s.
- Acknowledge path, entered from IDLE when init_done && int_s:
  - INTA1: INTA_LOW_CYC cycles low.
  - GAP: INTA_GAP_CYC cycles high.
  - INTA2: INTA_LOW_CYC cycles low; pic_din is sampled on the rising edge that ends INTA2.
  - VEC: vec_valid=1 for one cycle with vec_data.
  - Then, if aeoi=0, an EOI write (0, 8'h20); then IDLE.
- int_s falling after INTA1 has started is ignored; the sequence always completes.
- IDLE priority, highest first:
  1. init_start
  2. acknowledge (requires init_done)
  3. ocw_req
- ocw_req is accepted only in IDLE, so a requester must hold it until ocw_ack. ocw_req before init_done is serviced.

## Timing
- With default parameters, one write takes 4 cycles.
- Init with sngl=1, ic4=1 is 4 writes: init_done rises 16 cycles after the init_start edge (first W_SETUP is the next cycle).
- pic_int rising to INTA1 start is 3 cycles: 2 synchronizer cycles plus the IDLE decode cycle.
- From INTA1 start, vec_valid rises at cycle INTA_LOW_CYC*2 + INTA_GAP_CYC, which is 6 with defaults.
- The EOI W_SETUP immediately follows VEC.
- Asynchronous reset mid-write or mid-INTA forces wr_n and inta_n high at once. No partial pulse resumes, and init_done clears.
- pic_wr_n and pic_inta_n are never low in the same cycle.

## Structure
- Package pic_host_pkg holds:
  - the state enum: IDLE, W_SETUP, W_STRB, W_HOLD, INTA1, GAP, INTA2, VEC
  - the ICW/OCW bit-position constants
  - EOI_NS = 8'h20
- Sub-module pic_sync2 is the generic 2-flop synchronizer for pic_int.
- A single cycle counter is shared across W_STRB, INTA1, GAP and INTA2.
- A 3-bit init index steps through the byte list, skipping entries that are not enabled.

## Test plan
- Init with sngl=1, ic4=1, aeoi=0, base=5'h08, mask=8'hFB → writes (0,13),(1,40),(1,01),(1,FB) in order; init_done rises at cycle 16.
- Init with sngl=0, ic4=0, icw3=8'h04 → writes (0,10),(1,40),(1,04),(1,FB); no ICW4 write.
- After init, raise pic_int with pic_din=8'h42 → two INTA pulses each 2 cycles wide with a 2-cycle gap; vec_data=8'h42; then write (0,20).
- Same as the previous case with aeoi=1 → vector is captured and no EOI write follows.
- ocw_req (sel=10, data=8'hE7) raised together with int_s → acknowledge runs first; then ocw_ack pulses and (0,E7) is written.
- rst_n asserted during INTA2 → inta_n goes high immediately; all outputs return to reset values; init_done=0.

Source files
------------

// File: rtl/pic_host_sequencer_pkg.sv
// Shared types, bit positions and byte builders for the PIC host sequencer.
// Holds the FSM state enum, sampled init config and init byte list helpers.
package pic_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_STRB,
      W_HOLD,
      INTA1,
      GAP,
      INTA2,
      VEC
   } state_e;

   localparam int ICW1_D4   = 4;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_IC4  = 0;
   localparam int ICW4_AEOI = 1;
   localparam int ICW4_UPM  = 0;
   localparam int OCW_D4    = 4;
   localparam int OCW_D3    = 3;

   localparam logic [7:0] EOI_NS = 8'h20;

   localparam logic [2:0] IX_ICW1 = 3'd0;
   localparam logic [2:0] IX_ICW2 = 3'd1;
   localparam logic [2:0] IX_ICW3 = 3'd2;
   localparam logic [2:0] IX_ICW4 = 3'd3;
   localparam logic [2:0] IX_OCW1 = 3'd4;
   localparam logic [2:0] IX_DONE = 3'd5;

   typedef struct packed {
      logic       sngl;
      logic       ic4;
      logic       aeoi;
      logic [4:0] vec_base;
      logic [7:0] icw3;
      logic [7:0] mask;
   } cfg_t;

   // Next enabled entry of the init list; IX_DONE after OCW1.
   function automatic logic [2:0] next_idx(
      input logic [2:0] idx,
      input cfg_t       c
   );
      logic [2:0] n;
      case (idx)
         IX_ICW1: n = IX_ICW2;
         IX_ICW2: n = !c.sngl ? IX_ICW3 :
                      (c.ic4 ? IX_ICW4 : IX_OCW1);
         IX_ICW3: n = c.ic4 ? IX_ICW4 : IX_OCW1;
         IX_ICW4: n = IX_OCW1;
         default: n = IX_DONE;
      endcase
      return n;
   endfunction

   // Returns {a0, data} for one init list entry.
   function automatic logic [8:0] init_entry(
      input logic [2:0] idx,
      input cfg_t       c
   );
      logic [8:0] e;
      e = '0;
      case (idx)
         IX_ICW1: begin
            e[ICW1_D4]   = 1'b1;
            e[ICW1_SNGL] = c.sngl;
            e[ICW1_IC4]  = c.ic4;
         end
         IX_ICW2: e = {1'b1, c.vec_base, 3'b000};
         IX_ICW3: e = {1'b1, c.icw3};
         IX_ICW4: begin
            e[8]         = 1'b1;
            e[ICW4_AEOI] = c.aeoi;
            e[ICW4_UPM]  = 1'b1;
         end
         default: e = {1'b1, c.mask};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/pic_host_sequencer_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out).
module pic_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/pic_host_sequencer.sv
// CPU-side master for an 8259-style PIC: init writes, INTA cycles, EOI, OCWs.
// Ports: init/cfg inputs, OCW request/ack, PIC bus (a0/dout/wr_n/int/inta_n/din), vector out, status.
module pic_host_sequencer
   import pic_host_pkg::*;
#(
   parameter int WR_LOW_CYC   = 2,
   parameter int INTA_LOW_CYC = 2,
   parameter int INTA_GAP_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init_start,
   input  logic       cfg_sngl,
   input  logic       cfg_ic4,
   input  logic       cfg_aeoi,
   input  logic [4:0] cfg_vec_base,
   input  logic [7:0] cfg_icw3,
   input  logic [7:0] cfg_mask,
   input  logic       ocw_req,
   input  logic [1:0] ocw_sel,
   input  logic [7:0] ocw_data,
   output logic       ocw_ack,
   output logic       pic_a0,
   output logic [7:0] pic_dout,
   output logic       pic_wr_n,
   input  logic       pic_int,
   output logic       pic_inta_n,
   input  logic [7:0] pic_din,
   output logic       vec_valid,
   output logic [7:0] vec_data,
   output logic       init_done,
   output logic       busy
);

   localparam int CW = 16;
   localparam logic [CW-1:0] WR_LAST  = CW'(WR_LOW_CYC - 1);
   localparam logic [CW-1:0] LOW_LAST = CW'(INTA_LOW_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(INTA_GAP_CYC - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            init_act_q, init_act_d;
   logic            init_done_q, init_done_d;
   cfg_t            cfg_q, cfg_d;
   logic            a0_q, a0_d;
   logic [7:0]      dout_q, dout_d;
   logic [7:0]      vec_q, vec_d;
   logic            int_s;
   cfg_t            cfg_in;
   logic [2:0]      nxt;
   logic [8:0]      nxt_ent;

   pic_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pic_int),
      .q     (int_s)
   );

   assign cfg_in = '{
      sngl:     cfg_sngl,
      ic4:      cfg_ic4,
      aeoi:     cfg_aeoi,
      vec_base: cfg_vec_base,
      icw3:     cfg_icw3,
      mask:     cfg_mask
   };

   assign nxt     = next_idx(idx_q, cfg_q);
   assign nxt_ent = init_entry(nxt, cfg_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      init_act_d  = init_act_q;
      init_done_d = init_done_q;
      cfg_d       = cfg_q;
      a0_d        = a0_q;
      dout_d      = dout_q;
      vec_d       = vec_q;
      ocw_ack     = 1'b0;
      case (state_q)
         IDLE: begin
            if (init_start) begin
               cfg_d           = cfg_in;
               idx_d           = IX_ICW1;
               init_act_d      = 1'b1;
               init_done_d     = 1'b0;
               {a0_d, dout_d}  = init_entry(IX_ICW1, cfg_in);
               state_d         = W_SETUP;
            end else if (init_done_q && int_s) begin
               cnt_d   = '0;
               state_d = INTA1;
            end else if (ocw_req) begin
               ocw_ack    = 1'b1;
               init_act_d = 1'b0;
               // OCW2/OCW3 carry fixed D4/D3 bits that select the register.
               unique case (ocw_sel)
                  2'b01: begin
                     a0_d    = 1'b1;
                     dout_d  = ocw_data;
                     state_d = W_SETUP;
                  end
                  2'b10, 2'b11: begin
                     a0_d           = 1'b0;
                     dout_d         = ocw_data;
                     dout_d[OCW_D4] = 1'b0;
                     dout_d[OCW_D3] = ocw_sel[0];
                     state_d        = W_SETUP;
                  end
                  default: ;
               endcase
            end
         end
         W_SETUP: begin
            cnt_d   = '0;
            state_d = W_STRB;
         end
         W_STRB: begin
            if (cnt_q == WR_LAST) state_d = W_HOLD;
            else cnt_d = cnt_q + 1'b1;
         end
         W_HOLD: begin
            if (init_act_q && nxt != IX_DONE) begin
               idx_d          = nxt;
               {a0_d, dout_d} = nxt_ent;
               state_d        = W_SETUP;
            end else begin
               state_d = IDLE;
               if (init_act_q) begin
                  init_done_d = 1'b1;
                  init_act_d  = 1'b0;
               end
            end
         end
         INTA1: begin
            if (cnt_q == LOW_LAST) begin
               cnt_d   = '0;
               state_d = GAP;
            end else cnt_d = cnt_q + 1'b1;
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = INTA2;
            end else cnt_d = cnt_q + 1'b1;
         end
         INTA2: begin
            if (cnt_q == LOW_LAST) begin
               vec_d   = pic_din;
               state_d = VEC;
            end else cnt_d = cnt_q + 1'b1;
         end
         VEC: begin
            if (!cfg_q.aeoi) begin
               a0_d       = 1'b0;
               dout_d     = EOI_NS;
               init_act_d = 1'b0;
               state_d    = W_SETUP;
            end else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= IX_ICW1;
         init_act_q  <= 1'b0;
         init_done_q <= 1'b0;
         cfg_q       <= '0;
         a0_q        <= 1'b0;
         dout_q      <= 8'h00;
         vec_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         init_act_q  <= init_act_d;
         init_done_q <= init_done_d;
         cfg_q       <= cfg_d;
         a0_q        <= a0_d;
         dout_q      <= dout_d;
         vec_q       <= vec_d;
      end
   end

   // Strobes decode straight from state so reset releases them at once.
   assign pic_wr_n   = (state_q != W_STRB);
   assign pic_inta_n = !(state_q == INTA1 || state_q == INTA2);
   assign vec_valid  = (state_q == VEC);
   assign vec_data   = vec_q;
   assign pic_a0     = a0_q;
   assign pic_dout   = dout_q;
   assign init_done  = init_done_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer: init lists, INTA/EOI, OCWs, reset.
// Writes are logged by a bus monitor; each scenario task checks inline.
module tb_pic_host_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       init_start = 1'b0;
   logic       cfg_sngl = 1'b1;
   logic       cfg_ic4 = 1'b1;
   logic       cfg_aeoi = 1'b0;
   logic [4:0] cfg_vec_base = 5'h08;
   logic [7:0] cfg_icw3 = 8'h00;
   logic [7:0] cfg_mask = 8'hFB;
   logic       ocw_req = 1'b0;
   logic [1:0] ocw_sel = 2'b00;
   logic [7:0] ocw_data = 8'h00;
   logic       ocw_ack;
   logic       pic_a0;
   logic [7:0] pic_dout;
   logic       pic_wr_n;
   logic       pic_int = 1'b0;
   logic       pic_inta_n;
   logic [7:0] pic_din = 8'h00;
   logic       vec_valid;
   logic [7:0] vec_data;
   logic       init_done;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;

   pic_host_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .init_start   (init_start),
      .cfg_sngl     (cfg_sngl),
      .cfg_ic4      (cfg_ic4),
      .cfg_aeoi     (cfg_aeoi),
      .cfg_vec_base (cfg_vec_base),
      .cfg_icw3     (cfg_icw3),
      .cfg_mask     (cfg_mask),
      .ocw_req      (ocw_req),
      .ocw_sel      (ocw_sel),
      .ocw_data     (ocw_data),
      .ocw_ack      (ocw_ack),
      .pic_a0       (pic_a0),
      .pic_dout     (pic_dout),
      .pic_wr_n     (pic_wr_n),
      .pic_int      (pic_int),
      .pic_inta_n   (pic_inta_n),
      .pic_din      (pic_din),
      .vec_valid    (vec_valid),
      .vec_data     (vec_data),
      .init_done    (init_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Bus monitor: one log entry {a0,dout} plus strobe length per write.
   logic [8:0] wq[$];
   int         wlen[$];
   logic       in_wr = 1'b0;
   int         cur_len = 0;
   logic [8:0] cur_w = '0;
   logic       overlap = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_wr = 1'b0;
      end else begin
         if (!pic_wr_n && !pic_inta_n) overlap = 1'b1;
         if (!pic_wr_n) begin
            if (!in_wr) begin
               in_wr = 1'b1;
               cur_len = 0;
               cur_w = {pic_a0, pic_dout};
            end
            cur_len++;
         end else if (in_wr) begin
            wq.push_back(cur_w);
            wlen.push_back(cur_len);
            in_wr = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic do_init(
      input  logic       s,
      input  logic       i,
      input  logic       a,
      input  logic [7:0] w3,
      output int         cyc,
      output logic       b0,
      output logic       d0,
      output logic [8:0] w0
   );
      @(negedge clk);
      cfg_sngl = s;
      cfg_ic4 = i;
      cfg_aeoi = a;
      cfg_icw3 = w3;
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      b0 = busy;
      d0 = init_done;
      w0 = {pic_a0, pic_dout};
      cyc = 0;
      while (!init_done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_ack_start(input logic [7:0] din, output int cyc);
      @(negedge clk);
      pic_din = din;
      pic_int = 1'b1;
      cyc = 0;
      while (pic_inta_n && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_idle(output logic ok);
      int c;
      c = 0;
      while (busy && c < 40) begin
         @(negedge clk);
         c++;
      end
      ok = !busy;
   endtask

   task automatic do_ocw(
      input  logic [1:0] sel,
      input  logic [7:0] d,
      output logic       acked
   );
      logic ok;
      @(negedge clk);
      ocw_sel = sel;
      ocw_data = d;
      ocw_req = 1'b1;
      acked = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (ocw_ack) begin
            acked = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      ocw_req = 1'b0;
      @(negedge clk);
      wait_idle(ok);
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (pic_wr_n !== 1'b1) begin n_bad++; $display("FAIL reset wr_n: got %b want 1", pic_wr_n); end
      n_vec++; if (pic_inta_n !== 1'b1) begin n_bad++; $display("FAIL reset inta_n: got %b want 1", pic_inta_n); end
      n_vec++; if (pic_a0 !== 1'b0) begin n_bad++; $display("FAIL reset a0: got %b want 0", pic_a0); end
      n_vec++; if (pic_dout !== 8'h00) begin n_bad++; $display("FAIL reset dout: got %h want 00", pic_dout); end
      n_vec++; if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL reset vec_valid: got %b want 0", vec_valid); end
      n_vec++; if (vec_data !== 8'h00) begin n_bad++; $display("FAIL reset vec_data: got %h want 00", vec_data); end
      n_vec++; if (ocw_ack !== 1'b0) begin n_bad++; $display("FAIL reset ocw_ack: got %b want 0", ocw_ack); end
      n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset init_done: got %b want 0", init_done); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ocw_pre_init;
      int   base;
      logic ack;
      base = wq.size();
      do_ocw(2'b01, 8'hA5, ack);
      n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL pre_init ack: got %b want 1", ack); end
      n_vec++; if (wq.size() - base !== 1) begin n_bad++; $display("FAIL pre_init count: got %0d want 1", wq.size() - base); end
      if (wq.size() > base) begin
         n_vec++; if (wq[base] !== 9'h1A5) begin n_bad++; $display("FAIL pre_init write: got %h want 1a5", wq[base]); end
      end
      n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL pre_init init_done: got %b want 0", init_done); end
   endtask

   task automatic test_init_a;
      int         base;
      int         cyc;
      logic       b0;
      logic       d0;
      logic [8:0] w0;
      logic [8:0] exp_w [4];
      exp_w = '{9'h013, 9'h140, 9'h101, 9'h1FB};
      base = wq.size();
      do_init(1'b1, 1'b1, 1'b0, 8'h00, cyc, b0, d0, w0);
      n_vec++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL init_a busy: got %b want 1", b0); end
      n_vec++; if (w0 !== 9'h013) begin n_bad++; $display("FAIL init_a setup: got %h want 013", w0); end
      n_vec++; if (cyc !== 16) begin n_bad++; $display("FAIL init_a done_cycle: got %0d want 16", cyc); end
      n_vec++; if (wq.size() - base !== 4) begin n_bad++; $display("FAIL init_a count: got %0d want 4", wq.size() - base); end
      for (int k = 0; k < 4; k++) begin
         if (wq.size() > base + k) begin
            n_vec++; if (wq[base+k] !== exp_w[k]) begin n_bad++; $display("FAIL init_a write%0d: got %h want %h", k, wq[base+k], exp_w[k]); end
            n_vec++; if (wlen[base+k] !== 2) begin n_bad++; $display("FAIL init_a wlen%0d: got %0d want 2", k, wlen[base+k]); end
         end
      end
   endtask

   task automatic test_ack_eoi;
      int         base;
      int         cyc;
      logic       ok;
      logic [6:0] pat;
      pat = 7'b1001100;
      base = wq.size();
      do_ack_start(8'h42, cyc);
      n_vec++; if (cyc !== 3) begin n_bad++; $display("FAIL ack_eoi latency: got %0d want 3", cyc); end
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) pic_int = 1'b0;
         n_vec++; if (pic_inta_n !== pat[k]) begin n_bad++; $display("FAIL ack_eoi inta_n@%0d: got %b want %b", k, pic_inta_n, pat[k]); end
      end
      n_vec++; if (vec_valid !== 1'b1) begin n_bad++; $display("FAIL ack_eoi vec_valid: got %b want 1", vec_valid); end
      n_vec++; if (vec_data !== 8'h42) begin n_bad++; $display("FAIL ack_eoi vec_data: got %h want 42", vec_data); end
      @(negedge clk);
      n_vec++; if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL ack_eoi vec_pulse: got %b want 0", vec_valid); end
      n_vec++; if ({busy, pic_wr_n, pic_a0, pic_dout} !== {3'b110, 8'h20}) begin n_bad++; $display("FAIL ack_eoi eoi_setup: got %b%b%b %h want 110 20", busy, pic_wr_n, pic_a0, pic_dout); end
      wait_idle(ok);
      n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ack_eoi idle: got %b want 1", ok); end
      n_vec++; if (wq.size() - base !== 1) begin n_bad++; $display("FAIL ack_eoi count: got %0d want 1", wq.size() - base); end
      if (wq.size() > base) begin
         n_vec++; if (wq[base] !== 9'h020) begin n_bad++; $display("FAIL ack_eoi write: got %h want 020", wq[base]); end
      end
   endtask

   task automatic test_init_b;
      int         base;
      int         cyc;
      logic       b0;
      logic       d0;
      logic [8:0] w0;
      logic [8:0] exp_w [4];
      exp_w = '{9'h010, 9'h140, 9'h104, 9'h1FB};
      base = wq.size();
      do_init(1'b0, 1'b0, 1'b0, 8'h04, cyc, b0, d0, w0);
      n_vec++; if (d0 !== 1'b0) begin n_bad++; $display("FAIL init_b done_clear: got %b want 0", d0); end
      n_vec++; if (cyc !== 16) begin n_bad++; $display("FAIL init_b done_cycle: got %0d want 16", cyc); end
      n_vec++; if (wq.size() - base !== 4) begin n_bad++; $display("FAIL init_b count: got %0d want 4", wq.size() - base); end
      for (int k = 0; k < 4; k++) begin
         if (wq.size() > base + k) begin
            n_vec++; if (wq[base+k] !== exp_w[k]) begin n_bad++; $display("FAIL init_b write%0d: got %h want %h", k, wq[base+k], exp_w[k]); end
         end
      end
   endtask

   task automatic test_ocw_vs_ack;
      int   base;
      int   cyc;
      logic seen_inta;
      logic acked;
      logic ok;
      base = wq.size();
      @(negedge clk);
      pic_din = 8'h42;
      pic_int = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ocw_sel = 2'b10;
      ocw_data = 8'hE7;
      ocw_req = 1'b1;
      #1;
      n_vec++; if (ocw_ack !== 1'b0) begin n_bad++; $display("FAIL ocw_vs_ack early_ack: got %b want 0", ocw_ack); end
      seen_inta = 1'b0;
      acked = 1'b0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (!pic_inta_n) begin
            seen_inta = 1'b1;
            pic_int = 1'b0;
         end
         #1;
         if (ocw_ack) begin
            acked = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      ocw_req = 1'b0;
      @(negedge clk);
      wait_idle(ok);
      n_vec++; if (seen_inta !== 1'b1) begin n_bad++; $display("FAIL ocw_vs_ack inta_first: got %b want 1", seen_inta); end
      n_vec++; if (acked !== 1'b1) begin n_bad++; $display("FAIL ocw_vs_ack ack: got %b want 1", acked); end
      n_vec++; if (wq.size() - base !== 2) begin n_bad++; $display("FAIL ocw_vs_ack count: got %0d want 2", wq.size() - base); end
      if (wq.size() > base + 1) begin
         n_vec++; if (wq[base] !== 9'h020) begin n_bad++; $display("FAIL ocw_vs_ack eoi: got %h want 020", wq[base]); end
         n_vec++; if (wq[base+1] !== 9'h0E7) begin n_bad++; $display("FAIL ocw_vs_ack ocw2: got %h want 0e7", wq[base+1]); end
      end
   endtask

   task automatic test_ocw_enc;
      int   base;
      logic a1;
      logic a2;
      logic a3;
      base = wq.size();
      do_ocw(2'b01, 8'h5A, a1);
      do_ocw(2'b11, 8'hFF, a2);
      do_ocw(2'b00, 8'h33, a3);
      n_vec++; if ({a1, a2, a3} !== 3'b111) begin n_bad++; $display("FAIL ocw_enc acks: got %b want 111", {a1, a2, a3}); end
      n_vec++; if (wq.size() - base !== 2) begin n_bad++; $display("FAIL ocw_enc count: got %0d want 2", wq.size() - base); end
      if (wq.size() > base + 1) begin
         n_vec++; if (wq[base] !== 9'h15A) begin n_bad++; $display("FAIL ocw_enc ocw1: got %h want 15a", wq[base]); end
         n_vec++; if (wq[base+1] !== 9'h0EF) begin n_bad++; $display("FAIL ocw_enc ocw3: got %h want 0ef", wq[base+1]); end
      end
   endtask

   task automatic test_init_c;
      int         base;
      int         cyc;
      logic       b0;
      logic       d0;
      logic [8:0] w0;
      base = wq.size();
      do_init(1'b1, 1'b1, 1'b1, 8'h00, cyc, b0, d0, w0);
      n_vec++; if (cyc !== 16) begin n_bad++; $display("FAIL init_c done_cycle: got %0d want 16", cyc); end
      n_vec++; if (wq.size() - base !== 4) begin n_bad++; $display("FAIL init_c count: got %0d want 4", wq.size() - base); end
      if (wq.size() > base + 2) begin
         n_vec++; if (wq[base+2] !== 9'h103) begin n_bad++; $display("FAIL init_c icw4: got %h want 103", wq[base+2]); end
      end
   endtask

   task automatic test_ack_aeoi;
      int base;
      int cyc;
      base = wq.size();
      do_ack_start(8'h9C, cyc);
      n_vec++; if (cyc !== 3) begin n_bad++; $display("FAIL ack_aeoi latency: got %0d want 3", cyc); end
      pic_int = 1'b0;
      repeat (6) @(negedge clk);
      n_vec++; if ({vec_valid, vec_data} !== {1'b1, 8'h9C}) begin n_bad++; $display("FAIL ack_aeoi vec: got %b %h want 1 9c", vec_valid, vec_data); end
      @(negedge clk);
      n_vec++; if ({busy, pic_wr_n} !== 2'b01) begin n_bad++; $display("FAIL ack_aeoi idle: got %b%b want 01", busy, pic_wr_n); end
      repeat (4) @(negedge clk);
      n_vec++; if (wq.size() - base !== 0) begin n_bad++; $display("FAIL ack_aeoi no_eoi: got %0d want 0", wq.size() - base); end
   endtask

   task automatic test_reset_mid_inta;
      int cyc;
      do_ack_start(8'h42, cyc);
      repeat (4) @(negedge clk);
      n_vec++; if (pic_inta_n !== 1'b0) begin n_bad++; $display("FAIL rst_inta in_inta2: got %b want 0", pic_inta_n); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (pic_inta_n !== 1'b1) begin n_bad++; $display("FAIL rst_inta inta_n: got %b want 1", pic_inta_n); end
      n_vec++; if ({pic_wr_n, pic_a0, pic_dout} !== {2'b10, 8'h00}) begin n_bad++; $display("FAIL rst_inta bus: got %b%b %h want 10 00", pic_wr_n, pic_a0, pic_dout); end
      n_vec++; if ({vec_valid, vec_data} !== 9'h000) begin n_bad++; $display("FAIL rst_inta vec: got %b %h want 0 00", vec_valid, vec_data); end
      n_vec++; if ({ocw_ack, init_done, busy} !== 3'b000) begin n_bad++; $display("FAIL rst_inta status: got %b want 000", {ocw_ack, init_done, busy}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      n_vec++; if ({pic_inta_n, busy} !== 2'b10) begin n_bad++; $display("FAIL rst_inta no_resume: got %b%b want 10", pic_inta_n, busy); end
      pic_int = 1'b0;
   endtask

   task automatic test_no_overlap;
      n_vec++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL no_overlap: got %b want 0", overlap); end
   endtask

   initial begin
      test_reset();
      test_ocw_pre_init();
      test_init_a();
      test_ack_eoi();
      test_init_b();
      test_ocw_vs_ack();
      test_ocw_enc();
      test_init_c();
      test_ack_aeoi();
      test_reset_mid_inta();
      test_no_overlap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
